// File: rtl/ram_port_arbiter_pkg.sv
// Shared arbiter types: FSM state and RAM port owner encodings,
// plus the round-robin owner pick used in IDLE.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_CACHE = 1'b0,
    OWN_IO    = 1'b1
  } owner_e;

  // Single requester wins outright; on a tie the one that did not own the
  // port last time wins.
  function automatic owner_e pick_owner(input logic   c_req,
                                        input logic   io_req,
                                        input owner_e last);
    owner_e who;
    if (c_req && io_req) begin
      who = (last == OWN_CACHE) ? OWN_IO : OWN_CACHE;
    end else if (io_req) begin
      who = OWN_IO;
    end else begin
      who = OWN_CACHE;
    end
    return who;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_buffer.sv
// block_word_buffer: holds one cache block, written one word at a time.
//   clk_i, rst_i : clock, synchronous active-high clear
//   we_i         : write wdata_i into the word slot at offset_i
//   block_o      : assembled block
module block_word_buffer
  import ram_port_arbiter_pkg::*;
#(
  parameter int OFFSET_WIDTH = 3,
  parameter int DATA_WIDTH   = 32,
  localparam int BLOCK_WIDTH = DATA_WIDTH * (1 << OFFSET_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [OFFSET_WIDTH-1:0] offset_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [BLOCK_WIDTH-1:0]  block_o
);

  logic [BLOCK_WIDTH-1:0] block_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      block_q <= '0;
    end else if (we_i) begin
      block_q[offset_i*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
    end
  end

  assign block_o = block_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one word-wide RAM port between the cache manage
// unit (8-word block refill/writeback, port locked for the whole block) and
// one I/O master (single-word accesses). Each word: IDLE -> ISSUE (one m_en
// strobe) -> WAIT (MEM_LATENCY cycles, read data captured on the last) ->
// RESP (c_ready or io_ack pulse) -> IDLE.
//   c_*  : cache side request/response, c_rblock = assembled refill block
//   io_* : I/O master request/response
//   m_*  : RAM controller port
//   grant_io, arb_state : debug view of owner and FSM state
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int OFFSET_WIDTH = 3,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  localparam int BLOCK_SIZE  = 1 << OFFSET_WIDTH,
  localparam int BLOCK_WIDTH = DATA_WIDTH * BLOCK_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   c_en,
  input  logic                   c_write,
  input  logic [ADDR_WIDTH-1:0]  c_addr,
  input  logic [BLOCK_WIDTH-1:0] c_wblock,
  output logic                   c_ready,
  output logic [BLOCK_WIDTH-1:0] c_rblock,
  input  logic                   io_req,
  input  logic                   io_we,
  input  logic [ADDR_WIDTH-1:0]  io_addr,
  input  logic [DATA_WIDTH-1:0]  io_wdata,
  output logic                   io_ack,
  output logic [DATA_WIDTH-1:0]  io_rdata,
  output logic                   m_en,
  output logic                   m_we,
  output logic [ADDR_WIDTH-1:0]  m_addr,
  output logic [DATA_WIDTH-1:0]  m_wdata,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  output logic                   grant_io,
  output logic [1:0]             arb_state
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]        WAIT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [OFFSET_WIDTH-1:0] LAST_OFF  = '1;

  arb_state_e             state_q, state_d;
  owner_e                 owner_q, owner_d;
  owner_e                 last_owner_q, last_owner_d;
  logic                   lock_q, lock_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  io_rdata_q, io_rdata_d;

  logic                   grant;
  owner_e                 sel;
  logic [DATA_WIDTH-1:0]  c_word;
  logic                   buf_we;

  assign c_word = c_wblock[c_addr[OFFSET_WIDTH-1:0]*DATA_WIDTH +: DATA_WIDTH];

  // Refill words land in the block buffer on the last WAIT cycle.
  assign buf_we = (state_q == ST_WAIT) && (cnt_q == '0) &&
                  (owner_q == OWN_CACHE) && !we_q;

  block_word_buffer #(
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_rbuf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (buf_we),
    .offset_i(addr_q[OFFSET_WIDTH-1:0]),
    .wdata_i (m_rdata),
    .block_o (c_rblock)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CACHE;
      last_owner_q <= OWN_IO;
      lock_q       <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      io_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lock_q       <= lock_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      io_rdata_q   <= io_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lock_d       = lock_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    io_rdata_d   = io_rdata_q;
    grant        = 1'b0;
    sel          = OWN_CACHE;
    c_ready      = 1'b0;
    io_ack       = 1'b0;
    m_en         = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A locked port only serves the cache; a lock with no cache request
        // is dropped and arbitration resumes on the following IDLE cycle.
        if (lock_q) begin
          if (c_en) begin
            grant = 1'b1;
            sel   = OWN_CACHE;
          end else begin
            lock_d = 1'b0;
          end
        end else if (c_en || io_req) begin
          grant = 1'b1;
          sel   = pick_owner(c_en, io_req, last_owner_q);
        end

        if (grant) begin
          owner_d = sel;
          state_d = ST_ISSUE;
          if (sel == OWN_CACHE) begin
            addr_d  = c_addr;
            we_d    = c_write;
            wdata_d = c_word;
            lock_d  = 1'b1;
          end else begin
            addr_d  = io_addr;
            we_d    = io_we;
            wdata_d = io_wdata;
          end
        end
      end

      ST_ISSUE: begin
        m_en    = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        cnt_d   = WAIT_LAST;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          if ((owner_q == OWN_IO) && !we_q) begin
            io_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        if (owner_q == OWN_CACHE) begin
          c_ready = 1'b1;
          if (addr_q[OFFSET_WIDTH-1:0] == LAST_OFF) begin
            lock_d = 1'b0;
          end
        end else begin
          io_ack = 1'b1;
        end
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign io_rdata  = io_rdata_q;
  assign grant_io  = (state_q != ST_IDLE) && (owner_q == OWN_IO);
  assign arb_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  localparam int OW  = 3;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int BW  = DW * (1 << OW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_en = 1'b0;
  logic          c_write = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [BW-1:0] c_wblock = '0;
  logic          c_ready;
  logic [BW-1:0] c_rblock;
  logic          io_req = 1'b0;
  logic          io_we = 1'b0;
  logic [AW-1:0] io_addr = '0;
  logic [DW-1:0] io_wdata = '0;
  logic          io_ack;
  logic [DW-1:0] io_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          grant_io;
  logic [1:0]    arb_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_men = 0;
  int n_ready = 0;
  int n_ack = 0;
  int last_ready_cyc = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .OFFSET_WIDTH(OW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c_en     (c_en),
    .c_write  (c_write),
    .c_addr   (c_addr),
    .c_wblock (c_wblock),
    .c_ready  (c_ready),
    .c_rblock (c_rblock),
    .io_req   (io_req),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_ack   (io_ack),
    .io_rdata (io_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .grant_io (grant_io),
    .arb_state(arb_state)
  );

  // RAM content is a fixed function of the address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[13:0], 2'b01, ~a[15:0]};
  endfunction

  // RAM model: read data valid only LAT cycles after the strobe.
  logic [LAT-1:0] pv = '0;
  logic [AW-1:0]  pa [LAT];

  always @(posedge clk) begin
    pv[0] <= m_en && !m_we;
    pa[0] <= m_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign m_rdata = pv[LAT-1] ? mem_word(pa[LAT-1]) : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_en)    n_men   <= n_men + 1;
    if (c_ready) n_ready <= n_ready + 1;
    if (io_ack)  n_ack   <= n_ack + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return m_en;
      1:       return c_ready;
      default: return io_ack;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag, output int n);
    logic seen;
    n = 0;
    seen = sig_of(which);
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = sig_of(which);
    end
    check({tag, " seen"}, BW'(seen), BW'(1));
  endtask

  task automatic cache_word(input logic [AW-1:0] a, input logic wr,
                            input logic [DW-1:0] wexp, input logic chk_gap);
    int n;
    wait_sig(0, "cache m_en", n);
    check("cache m_addr", BW'(m_addr), BW'(a));
    check("cache m_we", BW'(m_we), BW'(wr));
    check("cache grant_io", BW'(grant_io), BW'(0));
    if (wr) check("cache m_wdata", BW'(m_wdata), BW'(wexp));
    wait_sig(1, "c_ready", n);
    check("c_ready latency", BW'(n), BW'(LAT + 1));
    if (chk_gap) check("c_ready spacing", BW'(cyc - last_ready_cyc), BW'(LAT + 3));
    last_ready_cyc = cyc;
  endtask

  function automatic logic [DW-1:0] wb_word(input int k);
    return 32'h5000_0000 | (k * 32'h0011_0000) | k;
  endfunction

  initial begin
    logic [BW-1:0] exp_blk;
    int n, men0, ack0, rdy0;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] exp_blk;
    int n, men0, ack0, rdy0;

    // Reset values
    tick(); tick();
    rst = 1'b0;
    check("rst arb_state", BW'(arb_state), BW'(0));
    check("rst c_rblock", c_rblock, '0);
    check("rst io_rdata", BW'(io_rdata), BW'(0));
    check("rst m_bus", BW'({m_en, m_we, m_addr, m_wdata}), BW'(0));
    check("rst strobes", BW'({c_ready, io_ack, grant_io}), BW'(0));
    tick();

    // Cache refill of block 0x100
    men0 = n_men; ack0 = n_ack;
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h100;
    for (int k = 0; k < 8; k++) begin
      cache_word(30'h100 + AW'(k), 1'b0, '0, k > 0);
      if (k < 7) c_addr = 30'h100 + AW'(k + 1);
      else       c_en = 1'b0;
    end
    for (int k = 0; k < 8; k++) exp_blk[k*DW +: DW] = mem_word(30'h100 + AW'(k));
    check("refill c_rblock", c_rblock, exp_blk);
    check("refill m_en count", BW'(n_men - men0), BW'(8));
    check("refill no io_ack", BW'(n_ack - ack0), BW'(0));

    // Cache writeback of block 0x200
    tick();
    for (int k = 0; k < 8; k++) c_wblock[k*DW +: DW] = wb_word(k);
    men0 = n_men; ack0 = n_ack;
    c_en = 1'b1; c_write = 1'b1; c_addr = 30'h200;
    for (int k = 0; k < 8; k++) begin
      cache_word(30'h200 + AW'(k), 1'b1, wb_word(k), k > 0);
      if (k < 7) c_addr = 30'h200 + AW'(k + 1);
      else       c_en = 1'b0;
    end
    check("wb c_rblock kept", c_rblock, exp_blk);
    check("wb m_en count", BW'(n_men - men0), BW'(8));
    check("wb no io_ack", BW'(n_ack - ack0), BW'(0));

    // I/O read alone, cycle-exact
    tick(); tick();
    io_req = 1'b1; io_we = 1'b0; io_addr = 30'h3A5;
    tick();
    check("io m_en t+1", BW'(m_en), BW'(1));
    check("io m_addr", BW'(m_addr), BW'(30'h3A5));
    check("io m_we", BW'(m_we), BW'(0));
    check("io grant_io", BW'(grant_io), BW'(1));
    tick();
    check("io m_en t+2", BW'(m_en), BW'(0));
    check("io state wait", BW'(arb_state), BW'(2));
    tick();
    check("io ack t+3", BW'(io_ack), BW'(0));
    tick();
    check("io ack t+4", BW'(io_ack), BW'(1));
    check("io rdata", BW'(io_rdata), BW'(mem_word(30'h3A5)));
    check("io no c_ready", BW'(c_ready), BW'(0));
    io_req = 1'b0;
    tick();
    check("io ack one pulse", BW'(io_ack), BW'(0));
    check("io state idle", BW'(arb_state), BW'(0));

    // I/O write keeps io_rdata
    io_req = 1'b1; io_we = 1'b1; io_addr = 30'h055; io_wdata = 32'hCAFE_F00D;
    wait_sig(0, "iow m_en", n);
    check("iow m_we", BW'(m_we), BW'(1));
    check("iow m_addr", BW'(m_addr), BW'(30'h055));
    check("iow m_wdata", BW'(m_wdata), BW'(32'hCAFE_F00D));
    wait_sig(2, "iow io_ack", n);
    check("iow ack latency", BW'(n), BW'(LAT + 1));
    check("iow io_rdata kept", BW'(io_rdata), BW'(mem_word(30'h3A5)));
    io_req = 1'b0; io_we = 1'b0;

    // io_req raised mid-block waits for the block, then beats a new block
    tick();
    ack0 = n_ack;
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h400;
    for (int k = 0; k < 8; k++) begin
      cache_word(30'h400 + AW'(k), 1'b0, '0, k > 0);
      if (k == 2) begin
        io_req = 1'b1; io_we = 1'b0; io_addr = 30'h777;
      end
      c_addr = (k < 7) ? 30'h400 + AW'(k + 1) : 30'h500;
    end
    check("lock no io_ack", BW'(n_ack - ack0), BW'(0));
    wait_sig(0, "rr io m_en", n);
    check("rr io m_addr", BW'(m_addr), BW'(30'h777));
    check("rr io grant_io", BW'(grant_io), BW'(1));
    wait_sig(2, "rr io_ack", n);
    check("rr io_rdata", BW'(io_rdata), BW'(mem_word(30'h777)));
    io_req = 1'b0;
    cache_word(30'h500, 1'b0, '0, 1'b0);
    c_en = 1'b0;
    for (int k = 1; k < 8; k++) exp_blk[k*DW +: DW] = mem_word(30'h400 + AW'(k));
    exp_blk[0 +: DW] = mem_word(30'h500);
    check("rr c_rblock", c_rblock, exp_blk);

    // Simultaneous requests after reset: cache block first, then I/O
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2 c_rblock", c_rblock, '0);
    check("rst2 io_rdata", BW'(io_rdata), BW'(0));
    c_en = 1'b1; c_write = 1'b0; c_addr = 30'h600;
    io_req = 1'b1; io_we = 1'b0; io_addr = 30'h123;
    for (int k = 0; k < 8; k++) begin
      cache_word(30'h600 + AW'(k), 1'b0, '0, k > 0);
      c_addr = 30'h600 + AW'(k + 1);
    end
    wait_sig(0, "tie io m_en", n);
    check("tie io m_addr", BW'(m_addr), BW'(30'h123));
    check("tie io grant_io", BW'(grant_io), BW'(1));
    wait_sig(2, "tie io_ack", n);
    check("tie io_rdata", BW'(io_rdata), BW'(mem_word(30'h123)));
    io_req = 1'b0;
    cache_word(30'h608, 1'b0, '0, 1'b0);
    c_en = 1'b0;

    // Reset during WAIT aborts the word silently
    tick(); tick();
    io_req = 1'b1; io_we = 1'b0; io_addr = 30'h0AA;
    tick();
    tick();
    check("abort state wait", BW'(arb_state), BW'(2));
    rst = 1'b1;
    ack0 = n_ack;
    tick();
    rst = 1'b0;
    check("abort state idle", BW'(arb_state), BW'(0));
    check("abort outputs", BW'({m_en, m_we, m_addr, m_wdata, c_ready, io_ack, grant_io}), BW'(0));
    check("abort io_rdata", BW'(io_rdata), BW'(0));
    check("abort c_rblock", c_rblock, '0);
    tick();
    check("retry m_en", BW'(m_en), BW'(1));
    check("retry m_addr", BW'(m_addr), BW'(30'h0AA));
    wait_sig(2, "retry io_ack", n);
    check("retry ack latency", BW'(n), BW'(LAT + 1));
    check("retry io_rdata", BW'(io_rdata), BW'(mem_word(30'h0AA)));
    check("retry single ack", BW'(n_ack + 1 - ack0), BW'(1));
    io_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
